// File: rtl/loba_sched_if.sv
// Request/response bundle for loba_sched: two request ports, one response port
// and the busy flag. The scheduler connects through the slave modport and the
// requesters/consumer drive the master side.
interface loba_sched_if #(
    parameter int N = 16
) ();
    logic           req0_valid;
    logic           req0_ready;
    logic [N-1:0]   req0_a;
    logic [N-1:0]   req0_b;
    logic           req1_valid;
    logic           req1_ready;
    logic [N-1:0]   req1_a;
    logic [N-1:0]   req1_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*N-1:0] rsp_p;
    logic           rsp_id;
    logic           busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_p, rsp_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_p, rsp_id, busy
    );
endinterface

// File: rtl/loba_sched.sv
// loba_sched: round-robin two-port front end for a serial LOBA approximate
// multiplier. Each accepted operand pair is split into high/low leading-one
// segments, the three retained partial products are formed one per cycle on a
// single KxK multiplier and summed into a 2N-bit accumulator, and the result
// is presented with the ID of the port that issued it.
module loba_sched #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    loba_sched_if.slave bus
);
    // Exponents never exceed N-K, so EW bits hold any leading-one index and
    // one extra bit holds the sum of two exponents.
    localparam int            EW  = $clog2(N);
    localparam int            SW  = EW + 1;
    localparam int            PW  = 2 * N;
    localparam logic [EW-1:0] KM1 = EW'(K - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECOMP,
        S_MUL0,
        S_MUL1,
        S_MUL2,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           ptr_q, ptr_d;      // last-served port
    logic           id_q, id_d;        // port of the in-flight transaction
    logic [PW-1:0]  acc_q, acc_d;

    logic           any_valid;
    logic           gnt;               // port that would be granted this cycle
    logic           accept;

    // Index 0 carries operand A, index 1 carries operand B.
    logic [N-1:0]   opnd_in [2];
    logic [K-1:0]   seg_h   [2];
    logic [K-1:0]   seg_l   [2];
    logic [EW-1:0]  exp_h   [2];
    logic [EW-1:0]  exp_l   [2];

    logic [K-1:0]   mul_a, mul_b;
    logic [2*K-1:0] prod;
    logic [SW-1:0]  mul_sh;
    logic [PW-1:0]  term;

    // Position of the highest set bit; zero for a zero input.
    function automatic logic [EW-1:0] msb_idx(input logic [N-1:0] x);
        logic [EW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) begin
                idx = EW'(i);
            end
        end
        return idx;
    endfunction

    // Round-robin grant: a lone requester wins, a tie goes to the port not last served.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        gnt       = (bus.req0_valid & bus.req1_valid) ? ~ptr_q : bus.req1_valid;
        accept    = (state_q == S_IDLE) & any_valid;
    end

    assign bus.req0_ready = accept & ~gnt;
    assign bus.req1_ready = accept &  gnt;
    assign opnd_in[0]     = gnt ? bus.req1_a : bus.req0_a;
    assign opnd_in[1]     = gnt ? bus.req1_b : bus.req0_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic [N-1:0]  opnd_q;
            logic [K-1:0]  seg_h_q, seg_l_q;
            logic [EW-1:0] exp_h_q, exp_l_q;
            logic [EW-1:0] m_hi, m_lo, e_hi, e_lo;
            logic [K-1:0]  h_seg, l_seg;
            logic [N-1:0]  rem;

            // Split the latched operand into its top K-bit window and the
            // top K-bit window of what remains below it.
            always_comb begin
                m_hi  = msb_idx(opnd_q);
                e_hi  = (m_hi >= KM1) ? (m_hi - KM1) : '0;
                h_seg = K'(opnd_q >> e_hi);
                rem   = opnd_q - (N'(h_seg) << e_hi);
                m_lo  = msb_idx(rem);
                e_lo  = (m_lo >= KM1) ? (m_lo - KM1) : '0;
                l_seg = K'(rem >> e_lo);
            end

            // Operand capture on accept; segments and exponents frozen in DECOMP.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    opnd_q  <= '0;
                    seg_h_q <= '0;
                    seg_l_q <= '0;
                    exp_h_q <= '0;
                    exp_l_q <= '0;
                end else begin
                    if (accept) begin
                        opnd_q <= opnd_in[gi];
                    end
                    if (state_q == S_DECOMP) begin
                        seg_h_q <= h_seg;
                        seg_l_q <= l_seg;
                        exp_h_q <= e_hi;
                        exp_l_q <= e_lo;
                    end
                end
            end

            assign seg_h[gi] = seg_h_q;
            assign seg_l[gi] = seg_l_q;
            assign exp_h[gi] = exp_h_q;
            assign exp_l[gi] = exp_l_q;
        end
    endgenerate

    // Single shared KxK multiplier, steered to one partial product per MUL state.
    always_comb begin
        mul_a  = '0;
        mul_b  = '0;
        mul_sh = '0;
        case (state_q)
            S_MUL0: begin
                mul_a  = seg_h[0];
                mul_b  = seg_h[1];
                mul_sh = SW'(exp_h[0]) + SW'(exp_h[1]);
            end
            S_MUL1: begin
                mul_a  = seg_h[0];
                mul_b  = seg_l[1];
                mul_sh = SW'(exp_h[0]) + SW'(exp_l[1]);
            end
            S_MUL2: begin
                mul_a  = seg_l[0];
                mul_b  = seg_h[1];
                mul_sh = SW'(exp_l[0]) + SW'(exp_h[1]);
            end
            default: ;
        endcase
        prod = {{K{1'b0}}, mul_a} * {{K{1'b0}}, mul_b};
        term = PW'(prod) << mul_sh;
    end

    // Sequencer next state: grant in IDLE, accumulate through MUL0..MUL2, hold DONE until taken.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    state_d = S_DECOMP;
                    ptr_d   = gnt;
                    id_d    = gnt;
                    acc_d   = '0;
                end
            end
            S_DECOMP: state_d = S_MUL0;
            S_MUL0: begin
                acc_d   = acc_q + term;
                state_d = S_MUL1;
            end
            S_MUL1: begin
                acc_d   = acc_q + term;
                state_d = S_MUL2;
            end
            S_MUL2: begin
                acc_d   = acc_q + term;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, pointer, ID and accumulator registers; reset abandons any in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b1;
            id_q    <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.rsp_valid = (state_q == S_DONE);
    assign bus.rsp_p     = acc_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule
